// File: rtl/reg_ctrl_pkg.sv
// Shared constants and state encoding for the register-bank transfer scheduler.
// Pure declarations: no latency, no backpressure.
package reg_ctrl_pkg;
  localparam int NREG_DEF = 8;
  localparam int SELW_DEF = 4;

  // Bus source select that drives a constant zero onto the internal bus.
  localparam logic [SELW_DEF-1:0] ZERO_SEL = '1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with a last-grant pointer.
// Grant is combinational from valid/en; pointer moves only on a grant; en low blocks all grants.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       en,
  output logic [1:0] grant
);
  logic ptr;

  // On contention the port that did not win last time is served.
  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b1;
    end else if (|grant) begin
      ptr <= grant[1];
    end
  end
endmodule

// File: rtl/reg_transfer_sched.sv
// Register-bank bus scheduler: clears the bank after reset, then arbitrates transfers.
// Grant-to-CE latency 1 cycle; STALL or INIT hold both READYs low.
module reg_transfer_sched
  import reg_ctrl_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int SELW = SELW_DEF
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            STALL,
  input  logic            REQ0_VALID,
  input  logic [SELW-1:0] REQ0_SRC,
  input  logic [SELW-1:0] REQ0_DST,
  output logic            REQ0_READY,
  input  logic            REQ1_VALID,
  input  logic [SELW-1:0] REQ1_SRC,
  input  logic [SELW-1:0] REQ1_DST,
  output logic            REQ1_READY,
  output logic [SELW-1:0] BUS_SEL,
  output logic [NREG-1:0] CE,
  output logic            ERR,
  output logic            BUSY
);
  localparam int IW = $clog2(NREG);
  localparam logic [SELW-1:0] ZERO_SRC = {SELW{1'b1}};

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [NREG-1:0] ce_q, ce_d;
  logic [SELW-1:0] bus_sel_q, bus_sel_d;
  logic            err_q, err_d;
  logic            tail_q, tail_d;

  logic            arb_en;
  logic [1:0]      grant;
  logic [SELW-1:0] gnt_src;
  logic [SELW-1:0] gnt_dst;

  // tail_q masks the cycle carrying the last INIT clear, so the first grant follows it.
  assign arb_en = (state_q == ST_RUN) && !tail_q && !STALL && !RST;

  rr_arb2 u_arb (
    .clk   (CLK),
    .rst   (RST),
    .valid ({REQ1_VALID, REQ0_VALID}),
    .en    (arb_en),
    .grant (grant)
  );

  assign gnt_src = grant[1] ? REQ1_SRC : REQ0_SRC;
  assign gnt_dst = grant[1] ? REQ1_DST : REQ0_DST;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ce_d      = '0;
    bus_sel_d = bus_sel_q;
    err_d     = 1'b0;
    tail_d    = 1'b0;
    case (state_q)
      ST_INIT: begin
        ce_d      = NREG'(1) << idx_q;
        bus_sel_d = ZERO_SRC;
        idx_d     = idx_q + IW'(1);
        if (idx_q == IW'(NREG - 1)) begin
          state_d = ST_RUN;
          tail_d  = 1'b1;
        end
      end
      ST_RUN: begin
        if (|grant) begin
          bus_sel_d = gnt_src;
          // Out-of-range destinations still occupy the slot but strobe nothing.
          if (gnt_dst < SELW'(NREG)) begin
            ce_d = NREG'(1) << gnt_dst;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_INIT;
      idx_q     <= '0;
      ce_q      <= '0;
      bus_sel_q <= ZERO_SRC;
      err_q     <= 1'b0;
      tail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ce_q      <= ce_d;
      bus_sel_q <= bus_sel_d;
      err_q     <= err_d;
      tail_q    <= tail_d;
    end
  end

  assign REQ0_READY = grant[0];
  assign REQ1_READY = grant[1];
  assign BUS_SEL    = bus_sel_q;
  assign CE         = ce_q;
  assign ERR        = err_q;
  assign BUSY       = (state_q == ST_INIT) || (|ce_q);
endmodule

// File: tb/tb_reg_transfer_sched.sv
// Directed bench for reg_transfer_sched: expected bus/CE/ERR records are queued by
// the stimulus and popped by a negedge monitor whenever CE or ERR is active.
module tb_reg_transfer_sched;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       STALL = 1'b0;
  logic       REQ0_VALID = 1'b0, REQ1_VALID = 1'b0;
  logic [3:0] REQ0_SRC = '0, REQ0_DST = '0, REQ1_SRC = '0, REQ1_DST = '0;
  logic       REQ0_READY, REQ1_READY;
  logic [3:0] BUS_SEL;
  logic [7:0] CE;
  logic       ERR, BUSY;

  typedef struct packed {
    logic [3:0] sel;
    logic [7:0] ce;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;

  reg_transfer_sched #(.NREG(8), .SELW(4)) dut (
    .CLK(CLK), .RST(RST), .STALL(STALL),
    .REQ0_VALID(REQ0_VALID), .REQ0_SRC(REQ0_SRC), .REQ0_DST(REQ0_DST), .REQ0_READY(REQ0_READY),
    .REQ1_VALID(REQ1_VALID), .REQ1_SRC(REQ1_SRC), .REQ1_DST(REQ1_DST), .REQ1_READY(REQ1_READY),
    .BUS_SEL(BUS_SEL), .CE(CE), .ERR(ERR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [3:0] sel, input logic [7:0] ce, input logic err);
    exp_t e;
    e.sel = sel; e.ce = ce; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic push_init();
    for (int i = 0; i < 8; i++) push(4'hF, 8'(1 << i), 1'b0);
  endtask

  // Monitor: every active output cycle must match the oldest queued expectation.
  always @(negedge CLK) begin
    if (CE !== 8'h00 || ERR !== 1'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {19'd0, BUS_SEL, CE, ERR}, 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("bus_ce_err", {19'd0, BUS_SEL, CE, ERR}, {19'd0, e});
      end
    end
  end

  initial begin
    // Reset with a request already pending; it must not be granted.
    REQ0_VALID = 1'b1; REQ0_SRC = 4'd2; REQ0_DST = 4'd5;
    cyc(); cyc();
    #1;
    chk("rst_ce", CE, 8'h00);
    chk("rst_bus_sel", BUS_SEL, 4'hF);
    chk("rst_err", ERR, 1'b0);
    chk("rst_busy", BUSY, 1'b1);
    chk("rst_ready0", REQ0_READY, 1'b0);

    // INIT aborted while CE=0x08.
    RST = 1'b0;
    for (int i = 0; i < 4; i++) push(4'hF, 8'(1 << i), 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("init1_ready0", REQ0_READY, 1'b0);
    end
    chk("init1_ce08", CE, 8'h08);
    RST = 1'b1;
    cyc();
    chk("midinit_rst_ce", CE, 8'h00);
    chk("midinit_rst_busy", BUSY, 1'b1);

    // Full INIT, READY stays low through the CE=0x80 cycle.
    RST = 1'b0;
    push_init();
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("init_ready0", REQ0_READY, 1'b0);
    end
    chk("init_last_ce", CE, 8'h80);
    cyc();
    #1;
    chk("run_ce_idle", CE, 8'h00);
    chk("run_busy_idle", BUSY, 1'b0);
    chk("single_ready0", REQ0_READY, 1'b1);
    push(4'd2, 8'h20, 1'b0);
    cyc();
    REQ0_VALID = 1'b0;
    #1;
    chk("single_busy", BUSY, 1'b1);
    cyc();
    chk("single_ce_after", CE, 8'h00);

    // Out-of-range destination from port 1 (pointer becomes 1).
    REQ1_VALID = 1'b1; REQ1_SRC = 4'd3; REQ1_DST = 4'd9;
    #1;
    chk("bad_ready1", REQ1_READY, 1'b1);
    chk("bad_ready0", REQ0_READY, 1'b0);
    push(4'd3, 8'h00, 1'b1);
    cyc();
    REQ1_VALID = 1'b0;
    #1;
    chk("bad_err", ERR, 1'b1);
    chk("bad_ce", CE, 8'h00);
    cyc();
    chk("bad_err_clear", ERR, 1'b0);

    // Contention: grants alternate 0,1,0,1.
    REQ0_VALID = 1'b1; REQ0_SRC = 4'd1; REQ0_DST = 4'd3;
    REQ1_VALID = 1'b1; REQ1_SRC = 4'd4; REQ1_DST = 4'd6;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("cont_ready0", REQ0_READY, (k % 2) == 0);
      chk("cont_ready1", REQ1_READY, (k % 2) == 1);
      if ((k % 2) == 0) push(4'd1, 8'h08, 1'b0);
      else push(4'd4, 8'h40, 1'b0);
      cyc();
    end

    // STALL blocks both ports; pointer unchanged so port 0 wins afterwards.
    STALL = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("stall_ready0", REQ0_READY, 1'b0);
      chk("stall_ready1", REQ1_READY, 1'b0);
      if (s > 0) chk("stall_ce", CE, 8'h00);
      cyc();
    end
    STALL = 1'b0;
    #1;
    chk("post_stall_ready0", REQ0_READY, 1'b1);
    chk("post_stall_ready1", REQ1_READY, 1'b0);
    push(4'd1, 8'h08, 1'b0);
    cyc();
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    cyc();

    // Reset while a transfer is on CE.
    REQ0_VALID = 1'b1; REQ0_SRC = 4'd5; REQ0_DST = 4'd1;
    #1;
    chk("run_rst_ready0", REQ0_READY, 1'b1);
    push(4'd5, 8'h02, 1'b0);
    cyc();
    REQ0_VALID = 1'b0;
    RST = 1'b1;
    cyc();
    chk("run_rst_ce", CE, 8'h00);
    chk("run_rst_bus_sel", BUS_SEL, 4'hF);
    chk("run_rst_busy", BUSY, 1'b1);
    RST = 1'b0;
    push_init();
    for (int i = 0; i < 10; i++) cyc();
    chk("run_idle_busy", BUSY, 1'b0);
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
